div_unit: RTL

Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions. It sits in the execute stage beside the ALU and accepts one operation per start pulse. While an operation is in flight it drives `div_unit_busy`, which the hazard controller uses to stall a following divide in decode. It returns a tagged result with a one-cycle `done` pulse for writeback.

---
 rtl/rv_div_pkg.sv | 26 ++
 rtl/div_step.sv | 23 ++
 rtl/div_unit.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/rv_div_pkg.sv
// Shared types and constants for the RV32M iterative divider.
// Operation encodings match the low two funct3 bits of DIV/DIVU/REM/REMU.
package rv_div_pkg;

  typedef enum logic [1:0] {
    OpDiv  = 2'b00,
    OpDivu = 2'b01,
    OpRem  = 2'b10,
    OpRemu = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StCalc = 2'b01,
    StFix  = 2'b10,
    StDone = 2'b11
  } div_state_e;

  localparam logic [31:0] INT_MIN = 32'h8000_0000;
  localparam logic [31:0] NEG_ONE = 32'hFFFF_FFFF;

  function automatic logic is_signed_op(div_op_e op);
    return (op == OpDiv) || (op == OpRem);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// trial-subtract the divisor, keep the difference if it did not go negative.
module div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN:0]   rem_in,
  input  logic [XLEN-1:0] divisor,
  input  logic            dividend_bit,
  output logic [XLEN:0]   rem_out,
  output logic            quo_bit
);

  logic [XLEN+1:0] shifted;
  logic [XLEN+1:0] diff;

  always_comb begin
    shifted = {rem_in, dividend_bit};
    diff    = shifted - {2'b00, divisor};
    quo_bit = ~diff[XLEN+1];
    rem_out = quo_bit ? diff[XLEN:0] : shifted[XLEN:0];
  end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Divides magnitudes over XLEN cycles, then applies sign correction in FIX.
module div_unit
  import rv_div_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            kill,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_in,
  output logic            div_unit_busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  div_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN:0]   rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dvsr_q;
  logic            op_rem_q;
  logic            q_neg_q;
  logic            r_neg_q;
  logic [4:0]      rd_q;
  logic            busy_q;
  logic            done_q;
  logic [XLEN-1:0] result_q;
  logic [4:0]      rd_out_q;

  logic            op_signed;
  logic            sign1;
  logic            sign2;
  logic [XLEN-1:0] abs1;
  logic [XLEN-1:0] abs2;
  logic            div_zero;
  logic            overflow;
  logic            special;
  logic [XLEN-1:0] special_res;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;
  logic [XLEN:0]   step_rem;
  logic            step_quo;

  always_comb begin
    op_signed   = is_signed_op(div_op_e'(op));
    sign1       = op_signed & rs1_val[XLEN-1];
    sign2       = op_signed & rs2_val[XLEN-1];
    abs1        = sign1 ? ('0 - rs1_val) : rs1_val;
    abs2        = sign2 ? ('0 - rs2_val) : rs2_val;
    div_zero    = (rs2_val == '0);
    overflow    = op_signed & (rs1_val == INT_MIN) & (rs2_val == NEG_ONE);
    special     = div_zero | overflow;
    // Divide-by-zero and overflow results come straight from RV32M rules.
    if (div_zero) begin
      special_res = op[1] ? rs1_val : '1;
    end else begin
      special_res = op[1] ? '0 : INT_MIN;
    end
    quo_fix = q_neg_q ? ('0 - quo_q) : quo_q;
    rem_fix = r_neg_q ? ('0 - rem_q[XLEN-1:0]) : rem_q[XLEN-1:0];
  end

  div_step #(
    .XLEN(XLEN)
  ) u_div_step (
    .rem_in       (rem_q),
    .divisor      (dvsr_q),
    .dividend_bit (quo_q[XLEN-1]),
    .rem_out      (step_rem),
    .quo_bit      (step_quo)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      op_rem_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      rd_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      rd_out_q <= '0;
    end else if (kill) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            op_rem_q <= op[1];
            q_neg_q  <= sign1 ^ sign2;
            r_neg_q  <= sign1;
            rd_q     <= rd_in;
            if (special) begin
              state_q  <= StDone;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              result_q <= special_res;
              rd_out_q <= rd_in;
            end else begin
              state_q <= StCalc;
              busy_q  <= 1'b1;
              cnt_q   <= CNT_W'(XLEN - 1);
              rem_q   <= '0;
              quo_q   <= abs1;
              dvsr_q  <= abs2;
            end
          end else begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        StCalc: begin
          // quo_q shifts the dividend out at the top and the quotient in at the bottom.
          rem_q <= step_rem;
          quo_q <= {quo_q[XLEN-2:0], step_quo};
          if (cnt_q == '0) begin
            state_q <= StFix;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StFix: begin
          state_q  <= StDone;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          result_q <= op_rem_q ? rem_fix : quo_fix;
          rd_out_q <= rd_q;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign div_unit_busy = busy_q;
  assign done          = done_q;
  assign result        = result_q;
  assign rd_out        = rd_out_q;

endmodule
